alu_op_sequencer: RTL and testbench

- Upstream issue and downstream capture stage for the 4-bit combinational ALU (select S[1:0], operands A/B[3:0], result C[3:0], carry C0).
- Accepts operation requests on a valid/ready handshake and registers S/A/B onto the ALU inputs.
- Waits a programmable settle time, then samples C/C0 into a result register presented on a second valid/ready handshake.
- Counts completed operations; the ALU itself stays external and combinational.

---
 rtl/alu_op_sequencer_if.sv | 35 +++
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request / ALU / result bundle for the ALU operation sequencer.
// The slave side is the sequencer; the master side is whoever issues
// requests, models the ALU and consumes results.
interface alu_op_sequencer_if #(
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_s;
    logic [3:0]         in_a;
    logic [3:0]         in_b;
    logic [1:0]         alu_s;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [3:0]         alu_c;
    logic               alu_c0;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_c;
    logic               out_c0;
    logic               out_zero;
    logic [COUNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_s, in_a, in_b, alu_c, alu_c0, out_ready,
        output in_ready, alu_s, alu_a, alu_b, out_valid, out_c, out_c0,
               out_zero, op_count
    );

    modport master (
        output in_valid, in_s, in_a, in_b, alu_c, alu_c0, out_ready,
        input  in_ready, alu_s, alu_a, alu_b, out_valid, out_c, out_c0,
               out_zero, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/capture sequencer wrapped around an external combinational 4-bit ALU.
// Operands are registered onto the ALU inputs on accept, the result is
// sampled SETTLE_CYCLES edges later and held on an output handshake.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int COUNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_op_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter reload value: the capture edge is the one where the counter reads 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         alu_s_q, alu_s_d;
    logic [3:0]         alu_a_q, alu_a_d;
    logic [3:0]         alu_b_q, alu_b_d;
    logic [3:0]         out_c_q, out_c_d;
    logic               out_c0_q, out_c0_d;
    logic               out_zero_q, out_zero_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic ready_raw_s;
    logic capture_s;
    logic in_ready_s;
    logic accept_s;
    logic out_valid_s;
    logic consume_s;

    // Handshake qualifiers; in_ready is forced low while reset is held.
    assign in_ready_s  = ready_raw_s & ~rst;
    assign accept_s    = bus.in_valid & in_ready_s;
    assign out_valid_s = (state_q == ST_HOLD);
    assign consume_s   = out_valid_s & bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a consume in HOLD may chain directly into a new op.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_SETTLE;
                else          state_d = ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_HOLD;
                else               state_d = ST_SETTLE;
            end
            ST_HOLD: begin
                if (consume_s && accept_s) state_d = ST_SETTLE;
                else if (consume_s)        state_d = ST_IDLE;
                else                       state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state controls: request readiness and the result capture strobe.
    always_comb begin
        ready_raw_s = 1'b0;
        capture_s   = 1'b0;
        case (state_q)
            ST_IDLE:   ready_raw_s = 1'b1;
            ST_SETTLE: capture_s   = (cnt_q == 4'd0);
            ST_HOLD:   ready_raw_s = bus.out_ready;
            default: begin
                ready_raw_s = 1'b0;
                capture_s   = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand launch, settle countdown, capture, counting.
    always_comb begin
        alu_s_d    = alu_s_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        cnt_d      = cnt_q;
        out_c_d    = out_c_q;
        out_c0_d   = out_c0_q;
        out_zero_d = out_zero_q;
        op_count_d = op_count_q;

        if (accept_s) begin
            alu_s_d = bus.in_s;
            alu_a_d = bus.in_a;
            alu_b_d = bus.in_b;
            cnt_d   = SETTLE_LOAD;
        end else if ((state_q == ST_SETTLE) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (capture_s) begin
            out_c_d    = bus.alu_c;
            out_c0_d   = bus.alu_c0;
            out_zero_d = (bus.alu_c == 4'h0);
        end else begin
            out_c_d    = out_c_q;
            out_c0_d   = out_c0_q;
            out_zero_d = out_zero_q;
        end

        if (consume_s) begin
            op_count_d = op_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Datapath registers; reset discards any in-flight or unconsumed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_s_q    <= 2'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            cnt_q      <= 4'd0;
            out_c_q    <= 4'd0;
            out_c0_q   <= 1'b0;
            out_zero_q <= 1'b0;
            op_count_q <= {COUNT_W{1'b0}};
        end else begin
            alu_s_q    <= alu_s_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            cnt_q      <= cnt_d;
            out_c_q    <= out_c_d;
            out_c0_q   <= out_c0_d;
            out_zero_q <= out_zero_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.alu_s     = alu_s_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.out_valid = out_valid_s;
    assign bus.out_c     = out_c_q;
    assign bus.out_c0    = out_c0_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: d1 uses SETTLE_CYCLES=1/COUNT_W=2,
// d3 uses SETTLE_CYCLES=3/COUNT_W=8 with a small stub ALU (C = A + 1).
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.COUNT_W(2)) b1 ();
    alu_op_sequencer_if #(.COUNT_W(8)) b3 ();

    alu_op_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(2)) d1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3), .COUNT_W(8)) d3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    logic       stub3_auto;
    logic [3:0] stub3_c;
    logic       stub3_c0;
    assign b3.alu_c  = stub3_auto ? (b3.alu_a + 4'd1) : stub3_c;
    assign b3.alu_c0 = stub3_auto ? 1'b0 : stub3_c0;

    logic [4:0] q1[$];
    logic [4:0] q3[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb1(input string tag);
        logic [4:0] e;
        if (q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
        end else begin
            e = q1.pop_front();
            chk({tag, "_c"},    32'(b1.out_c),    32'(e[3:0]));
            chk({tag, "_c0"},   32'(b1.out_c0),   32'(e[4]));
            chk({tag, "_zero"}, 32'(b1.out_zero), 32'(e[3:0] == 4'h0));
        end
    endtask

    task automatic sb3(input string tag);
        logic [4:0] e;
        if (q3.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
        end else begin
            e = q3.pop_front();
            chk({tag, "_c"},    32'(b3.out_c),    32'(e[3:0]));
            chk({tag, "_c0"},   32'(b3.out_c0),   32'(e[4]));
            chk({tag, "_zero"}, 32'(b3.out_zero), 32'(e[3:0] == 4'h0));
        end
    endtask

    initial begin
        logic [3:0] c6;
        int exp_cnt;
        rst = 1'b1;
        b1.in_valid = 1'b0; b1.in_s = 2'd0; b1.in_a = 4'd0; b1.in_b = 4'd0;
        b1.alu_c = 4'd0; b1.alu_c0 = 1'b0; b1.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_s = 2'd0; b3.in_a = 4'd0; b3.in_b = 4'd0;
        b3.out_ready = 1'b0;
        stub3_auto = 1'b0; stub3_c = 4'd0; stub3_c0 = 1'b0;

        // Reset state
        step(); step();
        chk("rst_in_ready",  32'(b1.in_ready),  32'd0);
        chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_alu_a",     32'(b1.alu_a),     32'd0);
        chk("rst_op_count",  32'(b1.op_count),  32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(b1.in_ready), 32'd1);

        // Test 1: single op on d1
        b1.in_valid = 1'b1; b1.in_s = 2'd0; b1.in_a = 4'h5; b1.in_b = 4'h4;
        b1.alu_c = 4'h9; b1.alu_c0 = 1'b1;
        q1.push_back({1'b1, 4'h9});
        step();
        b1.in_valid = 1'b0; b1.in_a = 4'hE;
        chk("t1_alu_s",     32'(b1.alu_s),     32'd0);
        chk("t1_alu_a",     32'(b1.alu_a),     32'h5);
        chk("t1_alu_b",     32'(b1.alu_b),     32'h4);
        chk("t1_valid_lo",  32'(b1.out_valid), 32'd0);
        step();
        chk("t1_valid_hi",  32'(b1.out_valid), 32'd1);
        sb1("t1");

        // Test 2: backpressure while the stub result changes
        b1.alu_c = 4'h3;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_hold_c",     32'(b1.out_c),     32'h9);
            chk("t2_hold_valid", 32'(b1.out_valid), 32'd1);
            chk("t2_in_ready",   32'(b1.in_ready),  32'd0);
            chk("t2_alu_a",      32'(b1.alu_a),     32'h5);
        end
        b1.out_ready = 1'b1;
        #1;
        chk("t2_ready_follow", 32'(b1.in_ready), 32'd1);
        step();
        chk("t2_consumed", 32'(b1.out_valid), 32'd0);
        chk("t2_op_count", 32'(b1.op_count),  32'd1);
        b1.out_ready = 1'b0;

        // Test 3: SETTLE_CYCLES=3 on d3, zero result, in_valid held during SETTLE
        stub3_c = 4'h0; stub3_c0 = 1'b0;
        b3.in_valid = 1'b1; b3.in_s = 2'd1; b3.in_a = 4'h7; b3.in_b = 4'h2;
        q3.push_back({1'b0, 4'h0});
        step();
        b3.in_a = 4'hF; b3.in_b = 4'hF;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("t3_valid_lo", 32'(b3.out_valid), 32'd0);
            chk("t3_in_ready", 32'(b3.in_ready),  32'd0);
            chk("t3_alu_a",    32'(b3.alu_a),     32'h7);
        end
        step();
        chk("t3_valid_hi", 32'(b3.out_valid), 32'd1);
        chk("t3_alu_b",    32'(b3.alu_b),     32'h2);
        sb3("t3");
        b3.in_valid = 1'b0;
        b3.out_ready = 1'b1;
        step();
        chk("t3_consumed", 32'(b3.out_valid), 32'd0);
        chk("t3_op_count", 32'(b3.op_count),  32'd1);

        // Test 4: back-to-back ops A=1..4, one result every 4 edges
        stub3_auto = 1'b1;
        b3.in_valid = 1'b1; b3.in_a = 4'd1; b3.in_b = 4'd0;
        q3.push_back({1'b0, 4'd2});
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("t4_alu_a", 32'(b3.alu_a), 32'(i));
            if (i < 4) begin
                b3.in_a = 4'(i + 1);
                q3.push_back({1'b0, 4'(i + 2)});
            end else begin
                b3.in_valid = 1'b0;
            end
            step(); step();
            chk("t4_valid_lo", 32'(b3.out_valid), 32'd0);
            step();
            chk("t4_valid_hi", 32'(b3.out_valid), 32'd1);
            sb3("t4");
            step();
        end
        chk("t4_done_valid", 32'(b3.out_valid), 32'd0);
        chk("t4_op_count",   32'(b3.op_count),  32'd5);
        chk("t4_in_ready",   32'(b3.in_ready),  32'd1);

        // Test 5a: reset while in SETTLE
        b3.in_valid = 1'b1; b3.in_a = 4'h9;
        step();
        b3.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5a_valid",    32'(b3.out_valid), 32'd0);
        chk("t5a_alu_a",    32'(b3.alu_a),     32'd0);
        chk("t5a_op_count", 32'(b3.op_count),  32'd0);
        chk("t5a_in_ready", 32'(b3.in_ready),  32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t5a_release_ready", 32'(b3.in_ready),  32'd1);
        step(); step(); step();
        chk("t5a_no_result",     32'(b3.out_valid), 32'd0);

        // Test 5b: reset while holding an unconsumed result
        b3.out_ready = 1'b0;
        b3.in_valid = 1'b1; b3.in_a = 4'h6;
        q3.push_back({1'b0, 4'h7});
        step();
        b3.in_valid = 1'b0;
        step(); step(); step();
        chk("t5b_valid_hi", 32'(b3.out_valid), 32'd1);
        sb3("t5b");
        rst = 1'b1;
        #1;
        chk("t5b_valid",    32'(b3.out_valid), 32'd0);
        chk("t5b_out_c",    32'(b3.out_c),     32'd0);
        chk("t5b_op_count", 32'(b3.op_count),  32'd0);
        chk("t5b_alu_a",    32'(b3.alu_a),     32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t5b_release_ready", 32'(b3.in_ready), 32'd1);
        chk("t5b_release_count", 32'(b3.op_count), 32'd0);

        // Test 6: COUNT_W=2 wrap on d1 over five consumes
        b1.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            c6 = 4'(i * 3);
            b1.in_valid = 1'b1; b1.in_s = 2'(i); b1.in_a = 4'(i); b1.in_b = 4'(i);
            step();
            b1.in_valid = 1'b0;
            b1.alu_c = c6; b1.alu_c0 = 1'(i);
            q1.push_back({1'(i), c6});
            step();
            chk("t6_valid_hi", 32'(b1.out_valid), 32'd1);
            sb1("t6");
            step();
            exp_cnt = i % 4;
            chk("t6_op_count", 32'(b1.op_count), 32'(exp_cnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
